instr_fetch_decode: RTL and testbench

- Front-end stage of the Beta-style CPU: holds the PC, fetches one 32-bit instruction word at a time over a variable-latency memory read port, and decodes it into fields.
- Decode covers the opcode, Rc/Ra/Rb, the sign-extended literal, and the string fields (datatype, charA/B/C).
- The decoded instruction goes to the execute stage over a valid/ready handshake.
- The stage accepts PC redirects (JMP/BEQ/BNE taken) from execute and halts after EXIT is consumed.

---
 rtl/instr_fetch_decode.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// Front-end stage: holds the PC, fetches one instruction word at a time over
// a variable-latency read port, decodes it and hands it to execute over a
// valid/ready handshake. Accepts PC redirects and stops after EXIT.
//
// state | meaning
// FETCH | mem_req issued for pc this cycle
// WAIT  | request outstanding, waiting for mem_valid
// HOLD  | decoded instruction presented, waiting for dec_ready
// DRAIN | discarding the response to a request made stale by a redirect
// HALT  | EXIT consumed, fetch stopped until rst
module instr_fetch_decode #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [5:0]        dec_opcode,
  output logic [4:0]        dec_rc,
  output logic [4:0]        dec_ra,
  output logic [4:0]        dec_rb,
  output logic [31:0]       dec_lit,
  output logic [1:0]        dec_datatype,
  output logic [20:0]       dec_chars,
  output logic [2:0]        dec_class,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [ADDR_W-1:0] dec_pc_plus4,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] C_NOOP    = 3'd0;
  localparam logic [2:0] C_ALU_REG = 3'd1;
  localparam logic [2:0] C_ALU_LIT = 3'd2;
  localparam logic [2:0] C_MEM     = 3'd3;
  localparam logic [2:0] C_CTRL    = 3'd4;
  localparam logic [2:0] C_DISP    = 3'd5;
  localparam logic [2:0] C_EXIT    = 3'd6;
  localparam logic [2:0] C_ILLEGAL = 3'd7;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       ir;
  logic              dec_valid_nxt;
  logic              capture;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_aligned;

  assign pc_inc           = pc + ADDR_W'(4);
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Request port: the address follows pc only while requesting, otherwise it
  // holds the last issued address. Requests are suppressed while rst is high.
  always_comb begin
    mem_req  = (state == S_FETCH) && !rst;
    mem_addr = (state == S_FETCH) ? pc : addr_q;
    halted   = (state == S_HALT);
  end

  // Field decode straight from the held instruction word (all zero after reset).
  always_comb begin
    dec_opcode   = ir[31:26];
    dec_rc       = ir[25:21];
    dec_ra       = ir[20:16];
    dec_rb       = ir[15:11];
    dec_lit      = {{16{ir[15]}}, ir[15:0]};
    dec_datatype = ir[25:24];
    dec_chars    = ir[23:3];
  end

  // Opcode class; the 0x27/0x2F/0x37/0x3F holes in the ALU ranges are illegal.
  always_comb begin
    dec_class = C_ILLEGAL;
    if (ir[31:26] == 6'h00)
      dec_class = C_NOOP;
    else if (ir[31:26] == 6'h01)
      dec_class = C_EXIT;
    else if (ir[31:30] == 2'b10 && ir[28:26] != 3'b111)
      dec_class = C_ALU_REG;
    else if (ir[31:30] == 2'b11 && ir[28:26] != 3'b111)
      dec_class = C_ALU_LIT;
    else begin
      case (ir[31:26])
        6'h18, 6'h19, 6'h1F: dec_class = C_MEM;
        6'h1B, 6'h1C, 6'h1D: dec_class = C_CTRL;
        6'h1A, 6'h1E:        dec_class = C_DISP;
        default:             dec_class = C_ILLEGAL;
      endcase
    end
  end

  // Next-state logic; redirect outranks both mem_valid and dec_ready.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    dec_valid_nxt = dec_valid;
    capture       = 1'b0;
    case (state)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_aligned;
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt        = redirect_aligned;
          dec_valid_nxt = 1'b0;
          state_nxt     = mem_valid ? S_FETCH : S_DRAIN;
        end else if (mem_valid) begin
          capture       = 1'b1;
          pc_nxt        = pc_inc;
          dec_valid_nxt = 1'b1;
          state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt        = redirect_aligned;
          dec_valid_nxt = 1'b0;
          state_nxt     = S_FETCH;
        end else if (dec_ready) begin
          dec_valid_nxt = 1'b0;
          state_nxt     = (dec_class == C_EXIT) ? S_HALT : S_FETCH;
        end
      end
      S_DRAIN: begin
        // A redirect landing together with the stale response still retires
        // it, otherwise the stage would wait forever for a second response.
        if (redirect_valid)
          pc_nxt = redirect_aligned;
        if (mem_valid)
          state_nxt = S_FETCH;
      end
      S_HALT: begin
        dec_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt     = S_FETCH;
        dec_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, PC, last address and decoded-instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      addr_q       <= RESET_PC;
      dec_valid    <= 1'b0;
      ir           <= '0;
      dec_pc       <= '0;
      dec_pc_plus4 <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      dec_valid <= dec_valid_nxt;
      if (state == S_FETCH)
        addr_q <= pc;
      if (capture) begin
        ir           <= mem_rdata;
        dec_pc       <= pc;
        dec_pc_plus4 <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode. Inputs change and outputs are
// checked on the falling edge; the DUT acts on the rising edge.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_opcode;
  logic [4:0]  dec_rc;
  logic [4:0]  dec_ra;
  logic [4:0]  dec_rb;
  logic [31:0] dec_lit;
  logic [1:0]  dec_datatype;
  logic [20:0] dec_chars;
  logic [2:0]  dec_class;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int tests = 0;
  int fails = 0;

  instr_fetch_decode #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_rc(dec_rc), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_lit(dec_lit), .dec_datatype(dec_datatype), .dec_chars(dec_chars),
    .dec_class(dec_class), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge of the FETCH cycle; returns at the falling
  // edge of the first HOLD cycle. lat = cycles from request to mem_valid.
  task automatic respond(input logic [31:0] word, input int lat);
    cyc;
    for (int i = 1; i < lat; i++) begin
      chk("wait_no_req", {31'b0, mem_req}, 32'd0);
      cyc;
    end
    mem_valid = 1'b1;
    mem_rdata = word;
    cyc;
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; mem_valid = 1'b0; mem_rdata = 32'h0; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    cyc; cyc;

    // reset state
    chk("rst_mem_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_opcode",    {26'b0, dec_opcode}, 32'd0);
    chk("rst_lit",       dec_lit, 32'h0);
    chk("rst_class",     {29'b0, dec_class}, 32'd0);
    chk("rst_pc_plus4",  dec_pc_plus4, 32'h0);
    chk("rst_halted",    {31'b0, halted}, 32'd0);

    // first fetch: ADDC R3,R1,-2 with 1-cycle memory
    rst = 1'b0;
    #1;
    chk("f1_req",  {31'b0, mem_req}, 32'd1);
    chk("f1_addr", mem_addr, 32'h0);
    respond(32'hC061FFFE, 1);
    chk("f1_valid",  {31'b0, dec_valid}, 32'd1);
    chk("f1_opcode", {26'b0, dec_opcode}, 32'h30);
    chk("f1_rc",     {27'b0, dec_rc}, 32'd3);
    chk("f1_ra",     {27'b0, dec_ra}, 32'd1);
    chk("f1_lit",    dec_lit, 32'hFFFFFFFE);
    chk("f1_class",  {29'b0, dec_class}, 32'd2);
    chk("f1_pc",     dec_pc, 32'h0);
    chk("f1_pc4",    dec_pc_plus4, 32'h4);
    chk("f1_noreq",  {31'b0, mem_req}, 32'd0);
    cyc;
    chk("f2_req",   {31'b0, mem_req}, 32'd1);
    chk("f2_addr",  mem_addr, 32'h4);
    chk("f2_valid", {31'b0, dec_valid}, 32'd0);

    // backpressure: ADD R5,R3,R2 held for several cycles
    dec_ready = 1'b0;
    respond(32'h80A31000, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",  {31'b0, dec_valid}, 32'd1);
      chk("hold_opcode", {26'b0, dec_opcode}, 32'h20);
      chk("hold_rc",     {27'b0, dec_rc}, 32'd5);
      chk("hold_ra",     {27'b0, dec_ra}, 32'd3);
      chk("hold_rb",     {27'b0, dec_rb}, 32'd2);
      chk("hold_lit",    dec_lit, 32'h00001000);
      chk("hold_class",  {29'b0, dec_class}, 32'd1);
      chk("hold_pc",     dec_pc, 32'h4);
      chk("hold_noreq",  {31'b0, mem_req}, 32'd0);
      cyc;
    end
    chk("hold_last_noreq", {31'b0, mem_req}, 32'd0);
    dec_ready = 1'b1;
    cyc;
    chk("f3_req",  {31'b0, mem_req}, 32'd1);
    chk("f3_addr", mem_addr, 32'h8);

    // redirect to 0x103 in the request cycle, memory latency 3
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    cyc;
    redirect_valid = 1'b0;
    chk("drain_noreq1", {31'b0, mem_req}, 32'd0);
    cyc;
    chk("drain_noreq2", {31'b0, mem_req}, 32'd0);
    chk("drain_novalid", {31'b0, dec_valid}, 32'd0);
    cyc;
    mem_valid = 1'b1; mem_rdata = 32'hC061FFFE;
    cyc;
    mem_valid = 1'b0; mem_rdata = 32'h0;
    chk("redir_req",     {31'b0, mem_req}, 32'd1);
    chk("redir_addr",    mem_addr, 32'h100);
    chk("redir_novalid", {31'b0, dec_valid}, 32'd0);

    // DISPC, datatype 2, "Hi!"
    w = {6'h1A, 2'b10, 7'h48, 7'h69, 7'h21, 3'b000};
    respond(w, 2);
    chk("disp_valid", {31'b0, dec_valid}, 32'd1);
    chk("disp_class", {29'b0, dec_class}, 32'd5);
    chk("disp_dtype", {30'b0, dec_datatype}, 32'd2);
    chk("disp_chars", {11'b0, dec_chars}, {11'b0, 7'h48, 7'h69, 7'h21});
    chk("disp_pc",    dec_pc, 32'h100);
    chk("disp_pc4",   dec_pc_plus4, 32'h104);
    cyc;
    chk("f4_addr", mem_addr, 32'h104);

    // illegal opcode 0x27 is delivered and fetch continues
    respond(32'h9C000000, 1);
    chk("ill_valid", {31'b0, dec_valid}, 32'd1);
    chk("ill_class", {29'b0, dec_class}, 32'd7);
    cyc;
    chk("ill_next_req",  {31'b0, mem_req}, 32'd1);
    chk("ill_next_addr", mem_addr, 32'h108);

    // redirect (unaligned) to the top of memory, then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFE;
    cyc;
    redirect_valid = 1'b0;
    mem_valid = 1'b1;
    cyc;
    mem_valid = 1'b0;
    chk("top_req",  {31'b0, mem_req}, 32'd1);
    chk("top_addr", mem_addr, 32'hFFFFFFFC);
    respond(32'hFC000000, 1);
    chk("top_class", {29'b0, dec_class}, 32'd7);
    chk("top_pc",    dec_pc, 32'hFFFFFFFC);
    chk("top_pc4",   dec_pc_plus4, 32'h0);
    cyc;
    chk("wrap_req",  {31'b0, mem_req}, 32'd1);
    chk("wrap_addr", mem_addr, 32'h0);

    // EXIT, then halt ignores redirect, rst restarts
    respond(32'h04000000, 1);
    chk("exit_class",  {29'b0, dec_class}, 32'd6);
    chk("exit_valid",  {31'b0, dec_valid}, 32'd1);
    chk("exit_halted", {31'b0, halted}, 32'd0);
    cyc;
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid",  {31'b0, dec_valid}, 32'd0);
    chk("halt_noreq",  {31'b0, mem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc; cyc;
    redirect_valid = 1'b0;
    chk("halt_redir_halted", {31'b0, halted}, 32'd1);
    chk("halt_redir_noreq",  {31'b0, mem_req}, 32'd0);
    rst = 1'b1;
    cyc;
    chk("rst2_halted", {31'b0, halted}, 32'd0);
    chk("rst2_noreq",  {31'b0, mem_req}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst2_req",  {31'b0, mem_req}, 32'd1);
    chk("rst2_addr", mem_addr, 32'h0);
    respond(32'h00000000, 1);
    chk("noop_valid", {31'b0, dec_valid}, 32'd1);
    chk("noop_class", {29'b0, dec_class}, 32'd0);
    chk("noop_pc",    dec_pc, 32'h0);
    cyc;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
